// File: rtl/matmul_tile_scheduler_pkg.sv
// Shared types, widths and defaults for the GEMM tile scheduler.
package matmul_tile_scheduler_pkg;

  localparam int DIM_W       = 32;
  localparam int SIZE_W      = 8;
  localparam int TILE_M_DEF  = 4;
  localparam int TILE_N_DEF  = 4;
  localparam int TILE_K_DEF  = 4;
  localparam int MAX_DIM_DEF = 1024;
  localparam int MAX_OUT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [DIM_W-1:0]  m_off;
    logic [DIM_W-1:0]  n_off;
    logic [DIM_W-1:0]  k_off;
    logic [SIZE_W-1:0] rows;
    logic [SIZE_W-1:0] cols;
    logic [SIZE_W-1:0] depth;
    logic              first_k;
    logic              last_k;
  } tile_cmd_t;

  // A dimension is usable when it is non-zero and within the supported maximum.
  function automatic logic dim_legal(input logic [DIM_W-1:0] dim,
                                     input logic [DIM_W-1:0] max_dim);
    return (dim != {DIM_W{1'b0}}) && (dim <= max_dim);
  endfunction

endpackage

// File: rtl/matmul_tile_scheduler_if.sv
// Tile command channel between the scheduler (master) and the compute core (slave).
interface matmul_tile_scheduler_if;
  import matmul_tile_scheduler_pkg::*;

  logic      valid;
  logic      ready;
  tile_cmd_t cmd;
  logic      done;

  modport master (output valid, output cmd, input ready, input done);
  modport slave  (input valid, input cmd, output ready, output done);

endinterface

// File: rtl/matmul_tile_scheduler_tile_dim_counter.sv
// One loop dimension: tile offset register plus clipped size and last-slice flag.
module tile_dim_counter
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int TILE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [DIM_W-1:0]  limit_i,
  output logic [DIM_W-1:0]  off_o,
  output logic [SIZE_W-1:0] size_o,
  output logic              last_o
);

  localparam logic [DIM_W-1:0] STEP = DIM_W'(TILE);

  logic [DIM_W-1:0] off_q;
  logic [DIM_W-1:0] off_d;
  logic [DIM_W-1:0] rem_s;
  logic [DIM_W:0]   reach_s;

  // Remaining extent decides the edge-tile size; one extra bit keeps the reach compare exact.
  always_comb begin
    rem_s   = limit_i - off_q;
    reach_s = {1'b0, off_q} + {1'b0, STEP};
    last_o  = (reach_s >= {1'b0, limit_i});
    if (rem_s >= STEP) begin
      size_o = SIZE_W'(TILE);
    end else begin
      size_o = rem_s[SIZE_W-1:0];
    end
  end

  // Offset next-state: clear on job start, step by one tile, wrap after the last slice.
  always_comb begin
    off_d = off_q;
    if (clear_i) begin
      off_d = {DIM_W{1'b0}};
    end else if (step_i) begin
      if (last_o) begin
        off_d = {DIM_W{1'b0}};
      end else begin
        off_d = off_q + STEP;
      end
    end else begin
      off_d = off_q;
    end
  end

  // Offset register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q <= {DIM_W{1'b0}};
    end else begin
      off_q <= off_d;
    end
  end

  assign off_o = off_q;

endmodule

// File: rtl/matmul_tile_scheduler.sv
// Walks an m x k x n GEMM (m outer, n middle, k inner) as tile commands,
// limiting in-flight tiles and signalling done once all issued tiles retire.
module matmul_tile_scheduler
  import matmul_tile_scheduler_pkg::*;
#(
  parameter int TILE_M  = TILE_M_DEF,
  parameter int TILE_N  = TILE_N_DEF,
  parameter int TILE_K  = TILE_K_DEF,
  parameter int MAX_DIM = MAX_DIM_DEF,
  parameter int MAX_OUT = MAX_OUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [DIM_W-1:0]        cfg_m_i,
  input  logic [DIM_W-1:0]        cfg_k_i,
  input  logic [DIM_W-1:0]        cfg_n_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  matmul_tile_scheduler_if.master tile_if
);

  localparam int               CNT_W   = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIM_W-1:0] DIM_MAX = DIM_W'(MAX_DIM);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] cfg_m_q, cfg_m_d;
  logic [DIM_W-1:0] cfg_k_q, cfg_k_d;
  logic [DIM_W-1:0] cfg_n_q, cfg_n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  tile_cmd_t        cmd_q, cmd_d;
  logic             valid_q, valid_d;
  logic             last_tile_q, last_tile_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             clear_s;
  logic             load_s;
  logic             hs_s;
  logic             retire_s;
  logic             cfg_ok_s;

  logic [DIM_W-1:0]  m_off_s, n_off_s, k_off_s;
  logic [SIZE_W-1:0] m_size_s, n_size_s, k_size_s;
  logic              m_last_s, n_last_s, k_last_s;

  assign clear_s  = (state_q == IDLE) && start_i;
  assign hs_s     = valid_q && tile_if.ready;
  assign retire_s = tile_if.done && (cnt_q != {CNT_W{1'b0}});
  assign cfg_ok_s = dim_legal(cfg_m_q, DIM_MAX) && dim_legal(cfg_k_q, DIM_MAX) &&
                    dim_legal(cfg_n_q, DIM_MAX);
  // The counters always point at the next tile to present, so a load both
  // captures the command and advances the loop nest.
  assign load_s   = ((state_q == CHECK) && cfg_ok_s) ||
                    ((state_q == ISSUE) && hs_s && !last_tile_q);

  tile_dim_counter #(.TILE(TILE_K)) u_k_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_s),
    .step_i  (load_s),
    .limit_i (cfg_k_q),
    .off_o   (k_off_s),
    .size_o  (k_size_s),
    .last_o  (k_last_s)
  );

  tile_dim_counter #(.TILE(TILE_N)) u_n_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_s),
    .step_i  (load_s && k_last_s),
    .limit_i (cfg_n_q),
    .off_o   (n_off_s),
    .size_o  (n_size_s),
    .last_o  (n_last_s)
  );

  tile_dim_counter #(.TILE(TILE_M)) u_m_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_s),
    .step_i  (load_s && k_last_s && n_last_s),
    .limit_i (cfg_m_q),
    .off_o   (m_off_s),
    .size_o  (m_size_s),
    .last_o  (m_last_s)
  );

  // In-flight count; a retire with no tiles outstanding is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (hs_s && !retire_s) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (!hs_s && retire_s) begin
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // FSM next-state, config latch, command load and registered-output next values.
  always_comb begin
    state_d     = state_q;
    cfg_m_d     = cfg_m_q;
    cfg_k_d     = cfg_k_q;
    cfg_n_d     = cfg_n_q;
    cmd_d       = cmd_q;
    last_tile_d = last_tile_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CHECK;
          cfg_m_d = cfg_m_i;
          cfg_k_d = cfg_k_i;
          cfg_n_d = cfg_n_i;
        end else begin
          state_d = IDLE;
        end
      end
      CHECK: begin
        if (cfg_ok_s) begin
          state_d = ISSUE;
        end else begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      ISSUE: begin
        if (hs_s && last_tile_q) begin
          state_d = DRAIN;
        end else begin
          state_d = ISSUE;
        end
      end
      DRAIN: begin
        if (cnt_d == {CNT_W{1'b0}}) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_s) begin
      cmd_d.m_off   = m_off_s;
      cmd_d.n_off   = n_off_s;
      cmd_d.k_off   = k_off_s;
      cmd_d.rows    = m_size_s;
      cmd_d.cols    = n_size_s;
      cmd_d.depth   = k_size_s;
      cmd_d.first_k = (k_off_s == {DIM_W{1'b0}});
      cmd_d.last_k  = k_last_s;
      last_tile_d   = m_last_s && n_last_s && k_last_s;
    end else begin
      cmd_d       = cmd_q;
      last_tile_d = last_tile_q;
    end

    valid_d = (state_d == ISSUE) && (cnt_d < CNT_MAX);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_m_q     <= {DIM_W{1'b0}};
      cfg_k_q     <= {DIM_W{1'b0}};
      cfg_n_q     <= {DIM_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      cmd_q       <= '0;
      valid_q     <= 1'b0;
      last_tile_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_m_q     <= cfg_m_d;
      cfg_k_q     <= cfg_k_d;
      cfg_n_q     <= cfg_n_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      valid_q     <= valid_d;
      last_tile_q <= last_tile_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign tile_if.valid = valid_q;
  assign tile_if.cmd   = cmd_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed bench for the GEMM tile scheduler with a small core model on the tile channel.
module tb_matmul_tile_scheduler;
  import matmul_tile_scheduler_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [DIM_W-1:0] cfg_m, cfg_k, cfg_n;
  logic             busy, done, err;

  matmul_tile_scheduler_if bus();

  matmul_tile_scheduler #(
    .TILE_M(4), .TILE_N(4), .TILE_K(4), .MAX_DIM(1024), .MAX_OUT(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .cfg_m_i (cfg_m),
    .cfg_k_i (cfg_k),
    .cfg_n_i (cfg_n),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err),
    .tile_if (bus)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  tile_cmd_t got_q[$];
  tile_cmd_t seq1[4];
  int        done_seen, err_seen, valid_seen, hs_cnt;
  bit        hs_neg = 1'b0;
  bit        auto_en = 1'b0;
  bit        manual_req = 1'b0;
  logic [2:0] pipe = 3'b000;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tile_cmd_t mk_cmd(input int m, input int n, input int k,
                                       input int r, input int c, input int d,
                                       input bit f, input bit l);
    tile_cmd_t t;
    t.m_off = DIM_W'(m);  t.n_off = DIM_W'(n);  t.k_off = DIM_W'(k);
    t.rows  = SIZE_W'(r); t.cols  = SIZE_W'(c); t.depth = SIZE_W'(d);
    t.first_k = f; t.last_k = l;
    return t;
  endfunction

  // Observe handshakes and pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    hs_neg = bus.valid && bus.ready;
    if (hs_neg) begin
      got_q.push_back(bus.cmd);
      hs_cnt++;
    end
    if (done) done_seen++;
    if (err) err_seen++;
    if (bus.valid) valid_seen++;
  end

  // Core model: tile_done three cycles after each accepted command, or on manual request.
  always @(posedge clk) begin
    #1;
    pipe = {pipe[1:0], hs_neg};
    bus.done = (auto_en && pipe[2]) || manual_req;
    manual_req = 1'b0;
  end

  task automatic clear_obs();
    got_q.delete();
    done_seen = 0; err_seen = 0; valid_seen = 0; hs_cnt = 0;
  endtask

  task automatic pulse_start(input int m, input int k, input int n);
    @(posedge clk); #1;
    cfg_m = DIM_W'(m); cfg_k = DIM_W'(k); cfg_n = DIM_W'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 300 && done_seen == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_eq({tag, "_done_pulses"}, 128'(done_seen), 128'd1);
    check_eq({tag, "_err_pulses"}, 128'(err_seen), 128'd0);
    check_eq({tag, "_busy_after"}, 128'(busy), 128'd0);
  endtask

  task automatic check_seq1(input string tag);
    check_eq({tag, "_cmd_count"}, 128'(got_q.size()), 128'd4);
    for (int i = 0; i < 4; i++) begin
      if (got_q.size() > i) check_eq($sformatf("%s_cmd%0d", tag, i), 128'(got_q[i]), 128'(seq1[i]));
    end
  endtask

  initial begin
    int bad_m[2];
    int bad_k[2];
    seq1[0] = mk_cmd(0, 0, 0, 4, 4, 4, 1'b1, 1'b0);
    seq1[1] = mk_cmd(0, 0, 4, 4, 4, 1, 1'b0, 1'b1);
    seq1[2] = mk_cmd(0, 4, 0, 4, 2, 4, 1'b1, 1'b0);
    seq1[3] = mk_cmd(0, 4, 4, 4, 2, 1, 1'b0, 1'b1);
    bad_m[0] = 0; bad_k[0] = 5;
    bad_m[1] = 4; bad_k[1] = 1025;

    rst_n = 1'b0; start = 1'b0; cfg_m = '0; cfg_k = '0; cfg_n = '0; bus.ready = 1'b0;
    clear_obs();
    #22;
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_done", 128'(done), 128'd0);
    check_eq("rst_err", 128'(err), 128'd0);
    check_eq("rst_valid", 128'(bus.valid), 128'd0);
    check_eq("rst_cmd", 128'(bus.cmd), 128'd0);
    @(negedge clk); rst_n = 1'b1;

    // Basic 4x5x6 job with a responsive core.
    bus.ready = 1'b1; auto_en = 1'b1; clear_obs();
    pulse_start(4, 5, 6);
    wait_done("t1");
    check_seq1("t1");

    // Illegal configurations finish with err and issue nothing.
    for (int c = 0; c < 2; c++) begin
      clear_obs();
      pulse_start(bad_m[c], bad_k[c], 6);
      check_eq($sformatf("t2_%0d_busy_e0", c), 128'(busy), 128'd1);
      check_eq($sformatf("t2_%0d_done_e0", c), 128'(done), 128'd0);
      @(posedge clk); #1;
      check_eq($sformatf("t2_%0d_done_e1", c), 128'(done), 128'd1);
      check_eq($sformatf("t2_%0d_err_e1", c), 128'(err), 128'd1);
      @(posedge clk); #1;
      check_eq($sformatf("t2_%0d_done_e2", c), 128'(done), 128'd0);
      check_eq($sformatf("t2_%0d_busy_e2", c), 128'(busy), 128'd0);
      repeat (3) @(negedge clk);
      check_eq($sformatf("t2_%0d_no_valid", c), 128'(valid_seen), 128'd0);
    end

    // Outstanding limit: completions withheld.
    auto_en = 1'b0; bus.ready = 1'b1; clear_obs();
    pulse_start(4, 16, 4);
    repeat (8) @(negedge clk);
    check_eq("t3_hs_capped", 128'(hs_cnt), 128'd2);
    check_eq("t3_valid_low", 128'(bus.valid), 128'd0);
    @(negedge clk); manual_req = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("t3_third_issue", 128'(hs_cnt), 128'd3);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); manual_req = 1'b1;
      repeat (3) @(negedge clk);
    end
    wait_done("t3");
    if (got_q.size() == 4) check_eq("t3_last_cmd", 128'(got_q[3]), 128'(mk_cmd(0, 0, 12, 4, 4, 4, 1'b0, 1'b1)));
    else check_eq("t3_cmd_count", 128'(got_q.size()), 128'd4);

    // Back-pressure stability, then a handshake coinciding with a completion.
    bus.ready = 1'b0; clear_obs();
    pulse_start(4, 8, 4);
    for (int i = 0; i < 20 && !bus.valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("t4_valid_hold%0d", i), 128'(bus.valid), 128'd1);
      check_eq($sformatf("t4_cmd_hold%0d", i), 128'(bus.cmd), 128'(mk_cmd(0, 0, 0, 4, 4, 4, 1'b1, 1'b0)));
    end
    @(posedge clk); #1 bus.ready = 1'b1;
    @(posedge clk); #1 bus.ready = 1'b0;
    @(negedge clk);
    check_eq("t4_second_valid", 128'(bus.valid), 128'd1);
    check_eq("t4_second_cmd", 128'(bus.cmd), 128'(mk_cmd(0, 0, 4, 4, 4, 4, 1'b0, 1'b1)));
    manual_req = 1'b1;
    @(posedge clk); #1 bus.ready = 1'b1;
    @(posedge clk); #1 bus.ready = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t4_hs_total", 128'(hs_cnt), 128'd2);
    check_eq("t4_no_early_done", 128'(done_seen), 128'd0);
    @(negedge clk); manual_req = 1'b1;
    wait_done("t4");

    // Start while busy is ignored.
    bus.ready = 1'b1; auto_en = 1'b1; clear_obs();
    pulse_start(4, 5, 6);
    repeat (3) @(posedge clk);
    #1; cfg_m = DIM_W'(8); cfg_k = DIM_W'(8); cfg_n = DIM_W'(8); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t5");
    check_seq1("t5");

    // Asynchronous reset mid-issue, then a clean rerun.
    bus.ready = 1'b0; clear_obs();
    pulse_start(4, 5, 6);
    for (int i = 0; i < 20 && !bus.valid; i++) @(negedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 128'(bus.valid), 128'd0);
    check_eq("t6_rst_busy", 128'(busy), 128'd0);
    check_eq("t6_rst_cmd", 128'(bus.cmd), 128'd0);
    @(negedge clk); manual_req = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); manual_req = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t6_idle_busy", 128'(busy), 128'd0);
    bus.ready = 1'b1; clear_obs();
    pulse_start(4, 5, 6);
    wait_done("t6");
    check_seq1("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
